// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: drives PC to a combinational instruction memory and
// holds one fetched instruction in a valid/ready output register for decode.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetchState_t;

    fetchState_t state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        outValid_q, outValid_d;
    logic [31:0] outInstr_q, outInstr_d;
    logic [31:0] outPc_q, outPc_d;
    logic [31:0] outPcPlus4_q, outPcPlus4_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetchCount_q, fetchCount_d;

    logic        transfer;
    logic [31:0] pcPlus4;
    logic [31:0] alignedTarget;
    logic        targetMisaligned;

    assign transfer         = outValid_q & out_ready;
    assign pcPlus4          = pc_q + 32'd4;
    assign alignedTarget    = {redirect_target[31:2], 2'b00};
    assign targetMisaligned = (redirect_target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            outValid_q   <= 1'b0;
            outInstr_q   <= 32'd0;
            outPc_q      <= 32'd0;
            outPcPlus4_q <= 32'd0;
            misalign_q   <= 1'b0;
            fetchCount_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            outValid_q   <= outValid_d;
            outInstr_q   <= outInstr_d;
            outPc_q      <= outPc_d;
            outPcPlus4_q <= outPcPlus4_d;
            misalign_q   <= misalign_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    // A transfer always completes and is counted, even when a redirect flushes
    // the register in the same cycle; halt_req stops new loads immediately.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        outValid_d   = outValid_q;
        outInstr_d   = outInstr_q;
        outPc_d      = outPc_q;
        outPcPlus4_d = outPcPlus4_q;
        misalign_d   = misalign_q;
        fetchCount_d = fetchCount_q;

        if (transfer) begin
            fetchCount_d = fetchCount_q + 32'd1;
            outValid_d   = 1'b0;
        end

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    pc_d       = alignedTarget;
                    outValid_d = 1'b0;
                    if (targetMisaligned) misalign_d = 1'b1;
                    if (halt_req) state_d = DRAIN;
                end else if (halt_req) begin
                    state_d = DRAIN;
                end else if (!outValid_q || transfer) begin
                    outInstr_d   = instruction;
                    outPc_d      = pc_q;
                    outPcPlus4_d = pcPlus4;
                    outValid_d   = 1'b1;
                    pc_d         = pcPlus4;
                end
            end
            DRAIN: begin
                if (!outValid_q) state_d = HALTED;
                if (redirect_valid) begin
                    pc_d       = alignedTarget;
                    outValid_d = 1'b0;
                    if (targetMisaligned) misalign_d = 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign PC           = pc_q;
    assign out_valid    = outValid_q;
    assign out_instr    = outInstr_q;
    assign out_pc       = outPc_q;
    assign out_pc_plus4 = outPcPlus4_q;
    assign halted       = (state_q == HALTED);
    assign misalign_err = misalign_q;
    assign fetch_count  = fetchCount_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the fetch stage.
module tb_mips_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 = fetching, 1 = draining, 2 = stopped.
    int          mMode;
    logic [31:0] mPc;
    logic        mValid;
    logic [31:0] mInstr;
    logic [31:0] mOutPc;
    logic        mMis;
    logic [31:0] mCount;

    mips_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .instruction     (instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .halted          (halted),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory image: word i holds i+1.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr / 32'd4) + 32'd1;
    endfunction

    assign instruction = memWord(PC);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mMode  = 0;
        mPc    = RESET_PC;
        mValid = 1'b0;
        mInstr = 32'd0;
        mOutPc = 32'd0;
        mMis   = 1'b0;
        mCount = 32'd0;
    endtask

    task automatic modelEdge(input logic rdy, input logic rv, input logic [31:0] rt, input logic hr);
        logic wasFull;
        logic accepted;
        wasFull  = mValid;
        accepted = wasFull && rdy;
        if (accepted) begin
            mCount = mCount + 1;
            mValid = 1'b0;
        end
        if (mMode == 2) return;
        if (mMode == 1 && !wasFull) mMode = 2;
        if (rv) begin
            mPc    = rt & 32'hFFFF_FFFC;
            mValid = 1'b0;
            if (rt % 4 != 0) mMis = 1'b1;
            if (hr && mMode == 0) mMode = 1;
        end else if (mMode == 0) begin
            if (hr) begin
                mMode = 1;
            end else if (!wasFull || accepted) begin
                mInstr = memWord(mPc);
                mOutPc = mPc;
                mValid = 1'b1;
                mPc    = mPc + 4;
            end
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".PC"}, PC, mPc);
        checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, mValid});
        checkOutput({tag, ".instr"}, out_instr, mInstr);
        checkOutput({tag, ".outpc"}, out_pc, mOutPc);
        checkOutput({tag, ".pc4"}, out_pc_plus4, (mInstr == 32'd0 && mOutPc == 32'd0) ? 32'd0 : mOutPc + 4);
        checkOutput({tag, ".halted"}, {31'd0, halted}, (mMode == 2) ? 32'd1 : 32'd0);
        checkOutput({tag, ".mis"}, {31'd0, misalign_err}, {31'd0, mMis});
        checkOutput({tag, ".count"}, fetch_count, mCount);
    endtask

    // Called just after a falling edge: drive, clock, then compare on the next falling edge.
    task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rt, input logic hr);
        out_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = rt;
        halt_req        = hr;
        @(posedge clk);
        modelEdge(rdy, rv, rt, hr);
        @(negedge clk);
        compareAll("step");
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic asyncReset();
        #1 rst = 1'b1;
        #1;
        modelReset();
        compareAll("arst");
        checkOutput("arst_pc_const", PC, RESET_PC);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int stoppedCycles;
        logic rdy, rv, hr;
        logic [31:0] rt;

        rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0;
        redirect_target = 32'd0; halt_req = 1'b0;
        #1 rst = 1'b1;
        #2;
        modelReset();
        compareAll("reset");
        @(negedge clk);
        rst = 1'b0;

        // Streaming at one instruction per cycle
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
            checkOutput("stream_instr", out_instr, i + 1);
            checkOutput("stream_pc", out_pc, i * 4);
            checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
        end

        // Stall with out_instr=5 held for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
            checkOutput("stall_instr", out_instr, 32'd5);
            checkOutput("stall_PC", PC, 32'h14);
            checkOutput("stall_count", fetch_count, 32'd4);
        end
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("resume_instr", out_instr, 32'd6);
        checkOutput("resume_count", fetch_count, 32'd5);

        // Aligned redirect with a simultaneous transfer
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0);
        checkOutput("redir_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("redir_PC", PC, 32'h40);
        checkOutput("redir_count", fetch_count, 32'd6);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("redir_outpc", out_pc, 32'h40);

        // Misaligned redirect is aligned and flagged stickily
        applyStimulus(1'b1, 1'b1, 32'h42, 1'b0);
        checkOutput("mis_PC", PC, 32'h40);
        checkOutput("mis_flag", {31'd0, misalign_err}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("mis_sticky", {31'd0, misalign_err}, 32'd1);

        // PC wraps past the top of the address space
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("wrap_outpc", out_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pc4", out_pc_plus4, 32'h0000_0000);
        checkOutput("wrap_PC", PC, 32'h0000_0000);

        // Halt while stalled, drain one transfer, then stop
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("drain_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("drain_hold", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("drain_empty", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("halted_flag", {31'd0, halted}, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h80, 1'b1);
        checkOutput("halted_stay", {31'd0, halted}, 32'd1);
        checkOutput("halted_novalid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a stall
        asyncReset();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        asyncReset();
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        checkOutput("post_rst_pc", out_pc, RESET_PC);
        checkOutput("post_rst_instr", out_instr, 32'd1);

        // Random traffic
        stoppedCycles = 0;
        for (int c = 0; c < 600; c++) begin
            if ((mMode == 2 && stoppedCycles > 3) || $urandom_range(0, 149) == 0) begin
                asyncReset();
                stoppedCycles = 0;
            end
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            hr  = ($urandom_range(0, 39) == 0);
            rt  = $urandom;
            if ($urandom_range(0, 1) == 0) rt = rt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) rt = 32'hFFFF_FFF0;
            applyStimulus(rdy, rv, rt, hr);
            if (mMode == 2) stoppedCycles++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port PC, output, 32 bits: fetch address driven to the instruction memory address input.
REQ-005 The block SHALL have port instruction, input, 32 bits: the instruction memory's combinational read data for PC, valid in the same cycle.
REQ-006 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-007 The block SHALL have port redirect_target, input, 32 bits: redirect address.
REQ-008 The block SHALL have port halt_req, input, 1 bit: request to stop fetching.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the output register holds an instruction.
REQ-010 The block SHALL have port out_ready, input, 1 bit: decode accepts; the transfer occurs when out_valid and out_ready are both 1.
REQ-011 The block SHALL have ports out_instr, output, 32 bits; out_pc, output, 32 bits; and out_pc_plus4, output, 32 bits: the registered instruction, its address, and its address + 4.
REQ-012 The block SHALL have port halted, output, 1 bit: the FSM is in HALTED.
REQ-013 The block SHALL have port misalign_err, output, 1 bit: sticky flag for a misaligned redirect.
REQ-014 The block SHALL have port fetch_count, output, 32 bits: count of accepted transfers.

Function
REQ-015 The FSM SHALL have states FETCH, DRAIN and HALTED.
REQ-016 In FETCH, when the output register is empty or is transferring this cycle, the block SHALL load instruction, PC and PC+4 into out_instr, out_pc and out_pc_plus4, set out_valid, and advance PC to PC+4.
REQ-017 If out_valid=1 and out_ready=0, the block SHALL hold PC and all out_* signals stable: no new load and no change to any output field.
REQ-018 Latency from a PC value to out_valid for that instruction SHALL be exactly 1 cycle; with out_ready held at 1, the block SHALL sustain one instruction per cycle.
REQ-019 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-020 On redirect_valid=1 in FETCH or DRAIN, PC SHALL become {redirect_target[31:2],2'b00} at the next edge, and out_valid SHALL clear at the next edge (flush); a transfer occurring in the same cycle SHALL still complete and be counted.
REQ-021 A redirect with redirect_target[1:0]!=0 SHALL set misalign_err, which SHALL stay set until rst.
REQ-022 On halt_req=1 in FETCH, the FSM SHALL go to DRAIN; in DRAIN no new loads SHALL occur and PC SHALL hold.
REQ-023 The FSM SHALL go from DRAIN to HALTED in the cycle after out_valid is 0, whether the register emptied by a transfer or by a flush.
REQ-024 HALTED SHALL be exited only by rst; redirect_valid and halt_req SHALL be ignored in HALTED, apart from the requirements stated above.
REQ-025 When redirect_valid and halt_req are both 1 in the same cycle, the redirect SHALL be applied (PC updated, register flushed), then the FSM SHALL enter DRAIN.
REQ-026 fetch_count SHALL increment by 1 on each transfer and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 halted SHALL be 1 only in HALTED.

Reset
REQ-028 While rst=1, regardless of clk, the block SHALL hold PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, fetch_count=0, misalign_err=0, halted=0, FSM=FETCH.
REQ-029 On reset assertion mid-stall, mid-drain or in HALTED, the block SHALL abandon all state immediately; the first fetch after release SHALL be at RESET_PC.

Verification
REQ-030 The bench SHALL release rst with out_ready=1 and a memory image of word i = i+1 -> out_instr sequence 1,2,3..., out_pc 0,4,8..., one per cycle, first out_valid 1 cycle after release.
REQ-031 The bench SHALL drop out_ready for 3 cycles with out_instr=5 -> out_instr=5 and PC=0x14 stable for 3 cycles, then resume at 6; fetch_count increments only on transfers.
REQ-032 The bench SHALL apply redirect_target=0x40 while out_valid=1 -> next cycle out_valid=0, PC=0x40; the cycle after, out_pc=0x40.
REQ-033 The bench SHALL apply redirect_target=0x42 -> PC=0x40 and misalign_err=1, which persists through subsequent fetches.
REQ-034 The bench SHALL assert halt_req with out_ready=0 -> DRAIN holds; after out_ready=1, one transfer occurs, then halted=1 and no further out_valid.
REQ-035 The bench SHALL assert rst asynchronously mid-stall -> all outputs reset without waiting for a clk edge; after release, fetch resumes at RESET_PC.
